// File: rtl/tempsens_sar_ctrl.sv
// SAR controller for the temperature-sensor DAC/comparator loop: binary-searches the DAC code
// against the synchronised comparator and returns the result with a one-cycle valid strobe.
module tempsens_sar_ctrl #(
   parameter int unsigned BITWIDTH      = 6,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic                i_comp,
   output logic [BITWIDTH-1:0] o_dac_data,
   output logic                o_dac_enable,
   output logic                o_busy,
   output logic [BITWIDTH-1:0] o_result,
   output logic                o_valid
);

   typedef enum logic [1:0] {StIdle, StSettle, StDecide} state_e;

   localparam int unsigned  IdxW    = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
   localparam logic [IdxW-1:0] IdxTop = IdxW'(BITWIDTH - 1);
   localparam logic [IdxW-1:0] IdxOne = IdxW'(1);
   localparam logic [7:0]   CntLoad = 8'(SETTLE_CYCLES - 1);

   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [BITWIDTH-1:0] dac_q, dac_d;
   logic                en_q, en_d;
   logic [BITWIDTH-1:0] result_q, result_d;
   logic                valid_q, valid_d;
   logic                sync_q, comp_s;
   logic [BITWIDTH-1:0] code;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q   <= 1'b0;
         comp_s   <= 1'b0;
         state_q  <= StIdle;
         idx_q    <= IdxTop;
         cnt_q    <= '0;
         dac_q    <= '0;
         en_q     <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         sync_q   <= i_comp;
         comp_s   <= sync_q;
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         dac_q    <= dac_d;
         en_q     <= en_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      dac_d    = dac_q;
      en_d     = en_q;
      result_d = result_q;
      valid_d  = 1'b0;
      code     = dac_q;

      unique case (state_q)
         StIdle: begin
            dac_d = '0;
            en_d  = 1'b0;
            if (i_start && !i_abort) begin
               dac_d[BITWIDTH-1] = 1'b1;
               idx_d             = IdxTop;
               cnt_d             = CntLoad;
               en_d              = 1'b1;
               state_d           = StSettle;
            end
         end
         StSettle: begin
            if (i_abort) begin
               dac_d   = '0;
               en_d    = 1'b0;
               idx_d   = IdxTop;
               state_d = StIdle;
            end else if (cnt_q == 8'd0) begin
               state_d = StDecide;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StDecide: begin
            if (i_abort) begin
               dac_d   = '0;
               en_d    = 1'b0;
               idx_d   = IdxTop;
               state_d = StIdle;
            end else begin
               // comp_s=1 means the sensed voltage is above the DAC, so the trial bit stays set
               if (!comp_s) code[idx_q] = 1'b0;
               if (idx_q != '0) begin
                  code[idx_q - IdxOne] = 1'b1;
                  dac_d                = code;
                  idx_d                = idx_q - IdxOne;
                  cnt_d                = CntLoad;
                  state_d              = StSettle;
               end else begin
                  result_d = code;
                  valid_d  = 1'b1;
                  dac_d    = '0;
                  en_d     = 1'b0;
                  idx_d    = IdxTop;
                  state_d  = StIdle;
               end
            end
         end
         default: begin
            dac_d   = '0;
            en_d    = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   assign o_dac_data   = dac_q;
   assign o_dac_enable = en_q;
   assign o_busy       = (state_q != StIdle);
   assign o_result     = result_q;
   assign o_valid      = valid_q;

endmodule

// File: tb/tb_tempsens_sar_ctrl.sv
// Directed bench for tempsens_sar_ctrl: ideal comparator models around three instances
// (SETTLE_CYCLES 4, 2 and 10) with hand-computed codes, latencies and results.
module tb_tempsens_sar_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [5:0] tgt;
   int         sel;

   logic [5:0] dac4, dac2, dac10, res4, res2, res10;
   logic       en4, en2, en10, busy4, busy2, busy10, val4, val2, val10;
   logic       comp4, comp2, comp10;

   assign comp4  = (tgt >= dac4);
   assign comp2  = (tgt >= dac2);
   assign comp10 = (tgt >= dac10);

   tempsens_sar_ctrl #(.BITWIDTH(6), .SETTLE_CYCLES(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start && (sel == 0)), .i_abort(abort),
      .i_comp(comp4), .o_dac_data(dac4), .o_dac_enable(en4), .o_busy(busy4),
      .o_result(res4), .o_valid(val4)
   );

   tempsens_sar_ctrl #(.BITWIDTH(6), .SETTLE_CYCLES(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start && (sel == 1)), .i_abort(1'b0),
      .i_comp(comp2), .o_dac_data(dac2), .o_dac_enable(en2), .o_busy(busy2),
      .o_result(res2), .o_valid(val2)
   );

   tempsens_sar_ctrl #(.BITWIDTH(6), .SETTLE_CYCLES(10)) dut10 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start && (sel == 2)), .i_abort(1'b0),
      .i_comp(comp10), .o_dac_data(dac10), .o_dac_enable(en10), .o_busy(busy10),
      .o_result(res10), .o_valid(val10)
   );

   logic [5:0] mon_dac, mon_res;
   logic       mon_en, mon_busy, mon_val;
   assign mon_dac  = (sel == 0) ? dac4  : (sel == 1) ? dac2  : dac10;
   assign mon_res  = (sel == 0) ? res4  : (sel == 1) ? res2  : res10;
   assign mon_en   = (sel == 0) ? en4   : (sel == 1) ? en2   : en10;
   assign mon_busy = (sel == 0) ? busy4 : (sel == 1) ? busy2 : busy10;
   assign mon_val  = (sel == 0) ? val4  : (sel == 1) ? val2  : val10;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int codes[$];
   int v_first, v_second, n_valid;
   int busy_at_v, ab_busy, ab_en, ab_dac;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start edge is E0; edge k of the loop is E(k). Inputs set before edge k are sampled there.
   task automatic run_conv(input int max_edges, input int repulse_at, input int abort_at,
                           input bit hold_start);
      codes.delete();
      v_first = -1; v_second = -1; n_valid = 0;
      busy_at_v = 1; ab_busy = 1; ab_en = 1; ab_dac = 63;
      start = 1'b1;
      @(posedge clk); #1;
      codes.push_back(int'(mon_dac));
      for (int k = 1; k <= max_edges; k++) begin
         start = hold_start || (k == repulse_at);
         abort = (k == abort_at);
         @(posedge clk); #1;
         if (mon_en && int'(mon_dac) != codes[$]) codes.push_back(int'(mon_dac));
         if (k == abort_at) begin
            ab_busy = int'(mon_busy);
            ab_en   = int'(mon_en);
            ab_dac  = int'(mon_dac);
         end
         if (mon_val) begin
            n_valid++;
            if (v_first < 0) begin
               v_first   = k;
               busy_at_v = int'(mon_busy);
            end else if (v_second < 0) begin
               v_second = k;
            end
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   int exp37[6] = '{32, 48, 40, 36, 38, 37};
   int exp21[6] = '{32, 16, 24, 20, 22, 21};

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; tgt = 6'd37; sel = 0;
      #12;
      check_eq("rst_dac", int'(dac4), 0);
      check_eq("rst_en", int'(en4), 0);
      check_eq("rst_busy", int'(busy4), 0);
      check_eq("rst_result", int'(res4), 0);
      check_eq("rst_valid", int'(val4), 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // T=37 nominal
      check_eq("idle_en_before", int'(mon_en), 0);
      run_conv(34, -1, -1, 1'b0);
      check_eq("t37_ncodes", codes.size(), 6);
      for (int i = 0; i < 6 && i < codes.size(); i++) check_eq("t37_code", codes[i], exp37[i]);
      check_eq("t37_latency", v_first, 30);
      check_eq("t37_nvalid", n_valid, 1);
      check_eq("t37_busy_at_valid", busy_at_v, 0);
      check_eq("t37_result", int'(mon_res), 37);
      check_eq("t37_en_after", int'(mon_en), 0);

      // Boundaries
      tgt = 6'd0;
      run_conv(34, -1, -1, 1'b0);
      check_eq("t0_result", int'(mon_res), 0);
      check_eq("t0_latency", v_first, 30);
      check_eq("t0_en_after", int'(mon_en), 0);
      tgt = 6'd63;
      check_eq("t63_en_before", int'(mon_en), 0);
      run_conv(34, -1, -1, 1'b0);
      check_eq("t63_result", int'(mon_res), 63);
      check_eq("t63_last_code", codes[$], 63);
      check_eq("t63_en_after", int'(mon_en), 0);

      // Settle sweep
      sel = 1; tgt = 6'd21;
      run_conv(22, -1, -1, 1'b0);
      check_eq("s2_ncodes", codes.size(), 6);
      for (int i = 0; i < 6 && i < codes.size(); i++) check_eq("s2_code", codes[i], exp21[i]);
      check_eq("s2_result", int'(mon_res), 21);
      check_eq("s2_latency", v_first, 18);
      sel = 2; tgt = 6'd37;
      run_conv(70, -1, -1, 1'b0);
      check_eq("s10_result", int'(mon_res), 37);
      check_eq("s10_latency", v_first, 66);
      sel = 0;

      // Start while busy is ignored
      run_conv(70, 10, -1, 1'b0);
      check_eq("restart_latency", v_first, 30);
      check_eq("restart_nvalid", n_valid, 1);

      // Start held: back-to-back conversions
      run_conv(70, -1, -1, 1'b1);
      check_eq("b2b_first", v_first, 30);
      check_eq("b2b_gap", v_second - v_first, 31);
      check_eq("b2b_nvalid", n_valid, 2);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_eq("b2b_abort_busy", int'(mon_busy), 0);

      // Abort mid-settle
      run_conv(40, -1, 12, 1'b0);
      check_eq("abort_busy", ab_busy, 0);
      check_eq("abort_en", ab_en, 0);
      check_eq("abort_dac", ab_dac, 0);
      check_eq("abort_nvalid", n_valid, 0);
      check_eq("abort_result", int'(mon_res), 37);

      // Abort on the final decide
      tgt = 6'd10;
      run_conv(40, -1, 30, 1'b0);
      check_eq("abort_final_nvalid", n_valid, 0);
      check_eq("abort_final_busy", int'(mon_busy), 0);
      check_eq("abort_final_result", int'(mon_res), 37);

      // Asynchronous reset mid-settle
      tgt = 6'd37;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      check_eq("pre_arst_en", int'(en4), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_dac", int'(dac4), 0);
      check_eq("arst_en", int'(en4), 0);
      check_eq("arst_busy", int'(busy4), 0);
      check_eq("arst_result", int'(res4), 0);
      check_eq("arst_valid", int'(val4), 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_conv(34, -1, -1, 1'b0);
      check_eq("post_arst_result", int'(mon_res), 37);
      check_eq("post_arst_latency", v_first, 30);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
